// File: rtl/smpte_bar_gen.sv
// SMPTE colour-bar timing generator: H/V counters, syncs, DE, frame_start and bar colours.
// Define SMPTE_PLUGE_EN to add the reverse-bar and PLUGE bands below the main bars.
module smpte_bar_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CW       = 12
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BW      = H_ACTIVE / 7;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BW_LAST  = CW'(BW - 1);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_cw_check
    $error("smpte_bar_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
  end
  if (H_ACTIVE < 7) begin : g_bw_check
    $error("smpte_bar_gen: H_ACTIVE must hold at least seven bars");
  end

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t main_bar(input logic [2:0] bar);
    case (bar)
      3'd0:    return '{8'd191, 8'd191, 8'd191};
      3'd1:    return '{8'd191, 8'd191, 8'd0};
      3'd2:    return '{8'd0,   8'd191, 8'd191};
      3'd3:    return '{8'd0,   8'd191, 8'd0};
      3'd4:    return '{8'd191, 8'd0,   8'd191};
      3'd5:    return '{8'd191, 8'd0,   8'd0};
      default: return '{8'd0,   8'd0,   8'd191};
    endcase
  endfunction

`ifdef SMPTE_PLUGE_EN
  localparam logic [CW-1:0] Y2_C = CW'((V_ACTIVE * 2) / 3);
  localparam logic [CW-1:0] Y3_C = CW'((V_ACTIVE * 3) / 4);

  function automatic rgb_t rev_bar(input logic [2:0] bar);
    case (bar)
      3'd0:    return '{8'd0,   8'd0,   8'd191};
      3'd2:    return '{8'd191, 8'd0,   8'd191};
      3'd4:    return '{8'd0,   8'd191, 8'd191};
      3'd6:    return '{8'd191, 8'd191, 8'd191};
      default: return '{8'd0,   8'd0,   8'd0};
    endcase
  endfunction

  function automatic rgb_t pluge_bar(input logic [2:0] bar);
    case (bar)
      3'd0:    return '{8'd0,   8'd33,  8'd76};
      3'd1:    return '{8'd255, 8'd255, 8'd255};
      3'd2:    return '{8'd50,  8'd0,   8'd106};
      3'd5:    return '{8'd10,  8'd10,  8'd10};
      default: return '{8'd0,   8'd0,   8'd0};
    endcase
  endfunction
`endif

  // Reset asserts immediately but releases only after two clean clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Counter stage: h/v position plus an incremental column/bar tracker (no divider).
  logic [CW-1:0] h_q, h_d, v_q, v_d, col_q, col_d;
  logic [2:0]    bar_q, bar_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    h_d   = h_q;
    v_d   = v_q;
    col_d = col_q;
    bar_d = bar_q;
    if (en) begin
      if (h_q == H_LAST) begin
        h_d   = '0;
        col_d = '0;
        bar_d = '0;
        v_d   = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
        if (col_q == BW_LAST) begin
          col_d = '0;
          if (bar_q != 3'd6) bar_d = bar_q + 3'd1;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  // Output stage: everything decoded from the counters and registered together.
  logic de_d, hs_d, vs_d, fs_d;
  rgb_t pix_d;

  always_comb begin
    de_d  = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hs_d  = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_ACT : ~HS_ACT;
    vs_d  = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_ACT : ~VS_ACT;
    fs_d  = (h_q == '0) && (v_q == '0);
    pix_d = '0;
    if (de_d) begin
`ifdef SMPTE_PLUGE_EN
      if (v_q < Y2_C)      pix_d = main_bar(bar_q);
      else if (v_q < Y3_C) pix_d = rev_bar(bar_q);
      else                 pix_d = pluge_bar(bar_q);
`else
      pix_d = main_bar(bar_q);
`endif
    end
  end

  logic          de_q, hs_q, vs_q, fs_q;
  rgb_t          pix_q;
  logic [CW-1:0] hcount_q, vcount_q;

  always_ff @(posedge pixel_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      h_q      <= '0;
      v_q      <= '0;
      col_q    <= '0;
      bar_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~HS_ACT;
      vs_q     <= ~VS_ACT;
      fs_q     <= 1'b0;
      pix_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      col_q <= col_d;
      bar_q <= bar_d;
      if (en) begin
        de_q     <= de_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        fs_q     <= fs_d;
        pix_q    <= pix_d;
        hcount_q <= h_q;
        vcount_q <= v_q;
      end else begin
        // The pulse must never be seen while timing is frozen.
        fs_q <= 1'b0;
      end
    end
  end

  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign red         = pix_q.r;
  assign green       = pix_q.g;
  assign blue        = pix_q.b;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;

endmodule

// File: tb/tb_smpte_bar_gen.sv
// Directed bench for smpte_bar_gen on a 20x16 raster (BW=2, Y2=8, Y3=9).
module tb_smpte_bar_gen;

  localparam int CW = 12;
  localparam int HT = 20;
  localparam int VT = 16;

  logic          pixel_clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          hsync, vsync, de, frame_start;
  logic [7:0]    red, green, blue;
  logic [CW-1:0] hcount, vcount;

  int n_checks = 0;
  int n_fail   = 0;
  int eh = 0;
  int ev = 0;
  int fs_seen = 0;
  int de_seen = 0;

  smpte_bar_gen #(
    .H_ACTIVE(14), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CW(CW)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .frame_start(frame_start),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hcount     (hcount),
    .vcount     (vcount)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, eh, ev);
    end
  endtask

  // Hand-written colour tables, indexed by bar.
  function automatic logic [23:0] main_c(input int b);
    logic [23:0] t [7];
    t = '{24'hBFBFBF, 24'hBFBF00, 24'h00BFBF, 24'h00BF00, 24'hBF00BF, 24'hBF0000, 24'h0000BF};
    return t[b];
  endfunction

  function automatic logic [23:0] exp_rgb(input int h, input int v);
    int b;
    logic [23:0] rev [7];
    logic [23:0] plg [7];
    rev = '{24'h0000BF, 24'h000000, 24'hBF00BF, 24'h000000, 24'h00BFBF, 24'h000000, 24'hBFBFBF};
    plg = '{24'h00214C, 24'hFFFFFF, 24'h32006A, 24'h000000, 24'h000000, 24'h0A0A0A, 24'h000000};
    if (!(h < 14 && v < 12)) return 24'h0;
    b = h / 2;
    if (b > 6) b = 6;
`ifdef SMPTE_PLUGE_EN
    if (v >= 9) return plg[b];
    if (v >= 8) return rev[b];
`else
    if (rev[0] == plg[0]) return 24'h0;  // tables differ; keeps both referenced
`endif
    return main_c(b);
  endfunction

  task automatic check_all();
    check("hcount", 32'(hcount), 32'(eh));
    check("vcount", 32'(vcount), 32'(ev));
    check("de", 32'(de), 32'(eh < 14 && ev < 12));
    check("hsync", 32'(hsync), 32'(eh >= 16 && eh < 19));
    check("vsync", 32'(vsync), 32'(ev >= 13 && ev < 15));
    check("frame_start", 32'(frame_start), 32'(eh == 0 && ev == 0));
    check("rgb", {8'h0, red, green, blue}, {8'h0, exp_rgb(eh, ev)});
    if (frame_start) fs_seen++;
    if (de) de_seen++;
  endtask

  task automatic advance();
    if (eh == HT - 1) begin
      eh = 0;
      ev = (ev == VT - 1) ? 0 : ev + 1;
    end else begin
      eh++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_de"}, 32'(de), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_rgb"}, {8'h0, red, green, blue}, 0);
    check({tag, "_hc"}, 32'(hcount), 0);
    check({tag, "_vc"}, 32'(vcount), 0);
    check({tag, "_hs"}, 32'(hsync), 0);
    check({tag, "_vs"}, 32'(vsync), 0);
  endtask

  task automatic wait_first_frame(input string tag);
    bit found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge pixel_clk);
      if (frame_start) found = 1;
      else check({tag, "_pre"}, 32'(de), 0);
    end
    check({tag, "_fs_seen"}, 32'(found), 1);
    eh = 0;
    ev = 0;
    if (found) check_all();
    advance();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pixel_clk);
      check_all();
      advance();
    end
  endtask

  task automatic run_until(input int th, input int tv);
    bit hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge pixel_clk);
      check_all();
      if (eh == th && ev == tv) hit = 1;
      else advance();
    end
    check("run_until_reached", 32'(hit), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge pixel_clk);
    check_reset("reset");

    // Two full frames from release.
    rst_n = 1'b1;
    fs_seen = 0;
    de_seen = 0;
    wait_first_frame("release");
    run_cycles(2 * HT * VT - 1);
    check("fs_per_2_frames", 32'(fs_seen), 2);
    check("de_per_2_frames", 32'(de_seen), 2 * 12 * 14);

    // Freeze at h=6, v=3 for five cycles.
    run_until(6, 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      check_all();
    end
    en = 1'b1;
    advance();
    run_cycles(1);
    check("resume_h7", 32'(hcount), 7);

    // Mid-frame reset at h=9, v=5.
    run_until(9, 5);
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (3) begin
      @(negedge pixel_clk);
      check_reset("in_rst");
    end
    rst_n = 1'b1;
    wait_first_frame("rerelease");
    run_cycles(2 * HT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
